// File: rtl/dac_sample_sink.sv
// dac_sample_sink: consumer end of the synth sample handshake.
// Requests one sample per PWM period (P = 2^CNT_W cycles), REQ_LEAD cycles before the wrap.
// Each accepted sample becomes the PWM duty for the following period.
// An underrun is flagged when a period ends with no new sample.
// Optional build macro SINK_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module dac_sample_sink #(
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned REQ_LEAD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pwm_out,
  output logic                period_start,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic [15:0]         underrun_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StHave} state_e;

  localparam int unsigned     Period = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] ReqPt  = CNT_W'(Period - REQ_LEAD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q, duty_d;
  // Only the top CNT_W bits of a sample ever reach the PWM, so only those are held.
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             underrun_q, underrun_d;
  logic             pwm_q;
  logic             period_start_q;
  logic             wrap;
  logic             underrun_event;
  logic             unused_sample;

  assign wrap           = en && (cnt_q == CntMax);
  assign sample_ready   = en && (state_q == StIdle) && (cnt_q == ReqPt);
  assign underrun_event = (state_q == StWait) && wrap && !sample_valid;
  // Low sample bits are truncated away by design.
  assign unused_sample  = ^{sample, 1'b0};

  // Next-state logic: request/capture handshake and duty hand-over at the period wrap.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (sample_ready) state_d = StWait;
      end
      StWait: begin
        if (wrap) begin
          // A sample landing on the wrap cycle goes straight to the duty register.
          if (sample_valid) duty_d = sample[SAMPLE_W-1 -: CNT_W];
          state_d = StIdle;
        end else if (sample_valid) begin
          pending_d = sample[SAMPLE_W-1 -: CNT_W];
          state_d   = StHave;
        end
      end
      StHave: begin
        if (wrap) begin
          duty_d  = pending_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  // Sticky underrun flag; a new event beats a simultaneous clear.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (underrun_event) underrun_d = 1'b1;
  end

  // State, period counter, duty and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      duty_q         <= '0;
      pending_q      <= '0;
      underrun_q     <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= en ? cnt_q + 1'b1 : '0;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      underrun_q     <= underrun_d;
      pwm_q          <= en && (cnt_q < duty_q);
      period_start_q <= wrap;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

`ifdef SINK_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun count; clear with a coincident event leaves exactly one.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr) begin
      ucnt_d = underrun_event ? 16'd1 : 16'd0;
    end else if (underrun_event && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun count register.
  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_sample_sink.sv
// Testbench for dac_sample_sink: period-level reference model with directed and random producers.
module tb_dac_sample_sink;

  localparam int P   = 1024;
  localparam int REQ = 1008;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [13:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        pwm_out;
  logic        period_start;
  logic        underrun;
  logic        underrun_clr;
  logic [15:0] underrun_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept per period.
  int m_duty = 0;
  bit m_unr  = 1'b0;
  int m_ucnt = 0;

  always #5 clk = ~clk;

  dac_sample_sink dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_ucnt();
`ifdef SINK_UNDERRUN_CNT_EN
    return m_ucnt;
`else
    return 0;
`endif
  endfunction

  // Duty is the sample divided down to the PWM resolution (truncating).
  function automatic int to_duty(input int s);
    return s / 16;
  endfunction

  // One PWM period starting at the negedge of the cnt==0 cycle.
  // kind: 0 no reply, 1 reply at REQ+d1, 2 reply on the wrap cycle, 3 replies at REQ+d1 and REQ+d2.
  task automatic run_period(input int kind, input int d1, input int d2, input int s1,
                            input int s2, input bit first, input int clr_at,
                            input int abort_at, input bit abort_rst);
    int highs = 0;
    for (int i = 0; i < P; i++) begin
      bit          v;
      logic [13:0] sv;
      chk("sample_ready", 32'(sample_ready), 32'(i == REQ));
      chk("period_start", 32'(period_start), 32'(i == 0 && !first));
      chk("underrun", 32'(underrun), 32'(m_unr));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_ucnt()));
      highs += int'(pwm_out);
      if (i == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else           en  = 1'b0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        @(negedge clk);
        return;
      end
      v  = 1'b0;
      sv = 14'($urandom);
      case (kind)
        1: if (i == REQ + d1) begin v = 1'b1; sv = 14'(s1); end
        2: if (i == P - 1) begin v = 1'b1; sv = 14'(s1); end
        3: begin
          if (i == REQ + d1) begin v = 1'b1; sv = 14'(s1); end
          else if (i == REQ + d2) begin v = 1'b1; sv = 14'(s2); end
        end
        default: ;
      endcase
      // Stray pulse while the sink has not asked for anything.
      if (i == 300) v = 1'b1;
      sample_valid = v;
      sample       = sv;
      underrun_clr = (i == clr_at);
      @(negedge clk);
      if (i == clr_at) begin
        m_unr  = 1'b0;
        m_ucnt = 0;
      end
      if (i == P - 1 && kind == 0) begin
        m_unr = 1'b1;
        if (m_ucnt < 65535) m_ucnt++;
      end
    end
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    chk("pwm_high_count", 32'(highs), 32'(m_duty));
    if (kind != 0) m_duty = to_duty(s1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sample_ready"}, 32'(sample_ready), 32'd0);
    chk({tag, "_pwm_out"}, 32'(pwm_out), 32'd0);
    chk({tag, "_period_start"}, 32'(period_start), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    sample       = '0;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    rst = 1'b0;
    en  = 1'b1;
    run_period(1, 3, 0, 'h2000, 0, 1'b1, -1, -1, 1'b0);  // first period silent
    run_period(1, 3, 0, 'h3FFF, 0, 1'b0, -1, -1, 1'b0);  // 512 high
    run_period(1, 3, 0, 'h0000, 0, 1'b0, -1, -1, 1'b0);  // 1023 high
    run_period(1, 3, 0, int'($urandom_range(0, 16383)), 0, 1'b0, -1, -1, 1'b0);  // 0 high
    run_period(0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b0);       // underrun at the wrap
    run_period(1, 5, 0, int'($urandom_range(0, 16383)), 0, 1'b0, 20, -1, 1'b0);  // repeat + clear
    run_period(2, 0, 0, 'h1000, 0, 1'b0, -1, -1, 1'b0);  // reply on the wrap cycle
    run_period(3, 2, 9, 'h1000, 'h3000, 1'b0, -1, -1, 1'b0);  // first capture wins
    run_period(0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b0);
    run_period(0, 0, 0, 0, 0, 1'b0, 1023, -1, 1'b0);     // clear coincides with event

    for (int k = 0; k < 6; k++) begin
      int kind = int'($urandom_range(0, 3));
      int d1   = int'($urandom_range(1, 13));
      int d2   = int'($urandom_range(d1 + 1, 14));
      int clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : -1;
      run_period(kind, d1, d2, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                 1'b0, clr, -1, 1'b0);
    end

    // Drop enable mid-period while the PWM is high.
    run_period(1, 4, 0, 'h3FFF, 0, 1'b0, 0, -1, 1'b0);
    run_period(1, 4, 0, int'($urandom_range(0, 16383)), 0, 1'b0, -1, 500, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("en_low_pwm_out", 32'(pwm_out), 32'd0);
      chk("en_low_sample_ready", 32'(sample_ready), 32'd0);
      chk("en_low_period_start", 32'(period_start), 32'd0);
      @(negedge clk);
    end
    en = 1'b1;
    run_period(1, 6, 0, int'($urandom_range(1024, 16383)), 0, 1'b1, -1, -1, 1'b0);

    // Reset while a captured sample is pending.
    run_period(1, 2, 0, int'($urandom_range(1024, 16383)), 0, 1'b0, -1, 1012, 1'b1);
    m_duty = 0;
    m_unr  = 1'b0;
    m_ucnt = 0;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    run_period(1, 3, 0, int'($urandom_range(0, 16383)), 0, 1'b1, -1, -1, 1'b0);
    run_period(0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b0);
    run_period(1, 3, 0, 0, 0, 1'b0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
